// File: rtl/enc_input_conditioner.sv
// enc_input_conditioner
//   Conditions raw encoder/pushbutton pads: 2-FF synchroniser per channel,
//   then a counter-based debounce FSM per channel. Produces a clean level
//   and one-cycle rise/fall strobes for the quadrature decoder (same clock).
//
//   Optional feature macro: ENC_COND_GLITCH_CNT_EN
//     When defined, each channel also gets an 8-bit saturating counter of
//     aborted debounce attempts (bounces), readable on o_glitch_cnt and
//     cleared synchronously by i_glitch_clr.
//
//   Debounce FSM states:
//     state     | meaning
//     ----------+------------------------------------------------------
//     ST_STABLE | synchronised input matches o_level, counter idle at 0
//     ST_COUNT  | input differs from o_level, counting stable cycles
//
//   Parameter constraints: NUM_CH >= 1, DEBOUNCE_CYCLES >= 2,
//   2**CNT_W > DEBOUNCE_CYCLES.

module enc_input_conditioner #(
  parameter int NUM_CH          = 3,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int CNT_W           = 18
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_CH-1:0]   i_raw,
`ifdef ENC_COND_GLITCH_CNT_EN
  input  logic                i_glitch_clr,
  output logic [8*NUM_CH-1:0] o_glitch_cnt,
`endif
  output logic [NUM_CH-1:0]   o_level,
  output logic [NUM_CH-1:0]   o_rise,
  output logic [NUM_CH-1:0]   o_fall
);

  localparam logic [0:0] ST_STABLE = 1'b0;
  localparam logic [0:0] ST_COUNT  = 1'b1;

  // Terminal count: the change is accepted when the counter reaches this value
  // while the input still differs from the current level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_CH-1:0] sync_q1;
  logic [NUM_CH-1:0] sync_q2;

  // Two-stage synchroniser; resets to the pulled-up (idle) pad level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= i_raw;
      sync_q2 <= sync_q1;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [0:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;
    logic             differs;
    logic             accept;
    logic             abort;

    assign differs = (sync_q2[ch] != level_q);
    assign accept  = (state_q == ST_COUNT) && differs && (cnt_q == CNT_LAST);
    assign abort   = (state_q == ST_COUNT) && !differs;

    // Debounce FSM: the level only follows the synchronised input after it has
    // differed for DEBOUNCE_CYCLES consecutive cycles; any return to the
    // current level throws the count away.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state_q <= ST_STABLE;
        cnt_q   <= '0;
        level_q <= 1'b1;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        case (state_q)
          ST_STABLE: begin
            if (differs) begin
              state_q <= ST_COUNT;
              cnt_q   <= CNT_W'(1);
            end else begin
              cnt_q   <= '0;
            end
          end
          ST_COUNT: begin
            if (accept) begin
              level_q <= sync_q2[ch];
              rise_q  <= sync_q2[ch];
              fall_q  <= !sync_q2[ch];
              cnt_q   <= '0;
              state_q <= ST_STABLE;
            end else if (abort) begin
              cnt_q   <= '0;
              state_q <= ST_STABLE;
            end else begin
              cnt_q   <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign o_level[ch] = level_q;
    assign o_rise[ch]  = rise_q;
    assign o_fall[ch]  = fall_q;

`ifdef ENC_COND_GLITCH_CNT_EN
    logic [7:0] glitch_q;

    // Saturating bounce counter; a clear in the same cycle as a bounce wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        glitch_q <= '0;
      end else if (i_glitch_clr) begin
        glitch_q <= '0;
      end else if (abort && (glitch_q != 8'hFF)) begin
        glitch_q <= glitch_q + 8'd1;
      end
    end

    assign o_glitch_cnt[8*ch +: 8] = glitch_q;
`endif
  end

endmodule

// File: tb/tb_enc_input_conditioner.sv
// tb_enc_input_conditioner
//   Directed bench for enc_input_conditioner with DEBOUNCE_CYCLES=4, NUM_CH=3.
//   Inputs change on the falling edge; outputs are sampled 1 time unit after
//   the rising edge. Edge k of a sequence is the k-th rising edge after the
//   new input value is applied.

module tb_enc_input_conditioner;

  localparam int NUM_CH = 3;
  localparam int DEB    = 4;
  localparam int CNT_W  = 3;

  logic              i_clk   = 1'b0;
  logic              i_rst_n = 1'b0;
  logic [NUM_CH-1:0] i_raw   = 3'b111;
  logic [NUM_CH-1:0] o_level;
  logic [NUM_CH-1:0] o_rise;
  logic [NUM_CH-1:0] o_fall;
`ifdef ENC_COND_GLITCH_CNT_EN
  logic              i_glitch_clr = 1'b0;
  logic [8*NUM_CH-1:0] o_glitch_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  enc_input_conditioner #(
    .NUM_CH          (NUM_CH),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (CNT_W)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_raw        (i_raw),
`ifdef ENC_COND_GLITCH_CNT_EN
    .i_glitch_clr (i_glitch_clr),
    .o_glitch_cnt (o_glitch_cnt),
`endif
    .o_level      (o_level),
    .o_rise       (o_rise),
    .o_fall       (o_fall)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [2:0] raw;
    logic [2:0] level;
    logic [2:0] rise;
    logic [2:0] fall;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [2:0] raw, input logic [2:0] level,
                     input logic [2:0] rise, input logic [2:0] fall,
                     input string name);
    vec_t v;
    v.raw   = raw;
    v.level = level;
    v.rise  = rise;
    v.fall  = fall;
    v.name  = name;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [2:0] level,
                            input logic [2:0] rise, input logic [2:0] fall);
    check({name, " level"}, 24'(o_level), 24'(level));
    check({name, " rise"},  24'(o_rise),  24'(rise));
    check({name, " fall"},  24'(o_fall),  24'(fall));
    check({name, " excl"},  24'(o_rise & o_fall), 24'(0));
  endtask

  task automatic step(input logic [2:0] raw);
    @(negedge i_clk);
    i_raw = raw;
    @(posedge i_clk);
    #1;
  endtask

`ifdef ENC_COND_GLITCH_CNT_EN
  task automatic gstep(input logic [2:0] raw, input logic clr);
    @(negedge i_clk);
    i_raw        = raw;
    i_glitch_clr = clr;
    @(posedge i_clk);
    #1;
  endtask

  task automatic bounce_ch0();
    gstep(3'b110, 1'b0);
    repeat (3) gstep(3'b111, 1'b0);
  endtask
`endif

  initial begin
    // Test 1: idle
    for (int k = 1; k <= 20; k++) add(3'b111, 3'b111, 3'b000, 3'b000, "idle");
    // Test 2: clean fall on ch0, then clean rise back
    for (int k = 1; k <= 9; k++)
      add(3'b110, (k >= 6) ? 3'b110 : 3'b111, 3'b000, (k == 6) ? 3'b001 : 3'b000, "ch0_fall");
    for (int k = 1; k <= 9; k++)
      add(3'b111, (k >= 6) ? 3'b111 : 3'b110, (k == 6) ? 3'b001 : 3'b000, 3'b000, "ch0_rise");
    // Test 3: 3-cycle pulse on ch1 is rejected
    for (int k = 1; k <= 3; k++) add(3'b101, 3'b111, 3'b000, 3'b000, "ch1_short");
    for (int k = 1; k <= 8; k++) add(3'b111, 3'b111, 3'b000, 3'b000, "ch1_short_rel");
    // Test 4: simultaneous fall on ch0 and ch2, then simultaneous rise
    for (int k = 1; k <= 8; k++)
      add(3'b010, (k >= 6) ? 3'b010 : 3'b111, 3'b000, (k == 6) ? 3'b101 : 3'b000, "ch02_fall");
    for (int k = 1; k <= 8; k++)
      add(3'b111, (k >= 6) ? 3'b111 : 3'b010, (k == 6) ? 3'b101 : 3'b000, 3'b000, "ch02_rise");
    // Boundary: a pulse of exactly DEB cycles on ch2 is accepted
    for (int k = 1; k <= 12; k++)
      add((k <= 4) ? 3'b011 : 3'b111,
          (k >= 6 && k <= 9) ? 3'b011 : 3'b111,
          (k == 10) ? 3'b100 : 3'b000,
          (k == 6) ? 3'b100 : 3'b000, "ch2_exact");

    // Reset state
    i_rst_n = 1'b0;
    i_raw   = 3'b111;
    repeat (3) @(posedge i_clk);
    #1;
    check_outs("reset", 3'b111, 3'b000, 3'b000);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].raw);
      check_outs(vecs[i].name, vecs[i].level, vecs[i].rise, vecs[i].fall);
    end

`ifdef ENC_COND_GLITCH_CNT_EN
    check("glitch_after_table", o_glitch_cnt, 24'h000100);
`endif

    // Test 5: bring ch0 low first so reset visibly forces the level high
    for (int k = 1; k <= 6; k++) step(3'b110);
    check_outs("pre_rst_ch0_low", 3'b110, 3'b000, 3'b001);
    for (int k = 1; k <= 3; k++) begin
      step(3'b010);
      check_outs("pre_rst_ch2_count", 3'b110, 3'b000, 3'b000);
    end
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check_outs("rst_immediate", 3'b111, 3'b000, 3'b000);
    repeat (2) @(posedge i_clk);
    #1;
    check_outs("rst_held", 3'b111, 3'b000, 3'b000);
`ifdef ENC_COND_GLITCH_CNT_EN
    check("glitch_rst", o_glitch_cnt, 24'h000000);
`endif
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    check_outs("post_rst_e1", 3'b111, 3'b000, 3'b000);
    for (int k = 2; k <= 7; k++) begin
      step(3'b010);
      check_outs("post_rst", (k >= 6) ? 3'b010 : 3'b111, 3'b000,
                 (k == 6) ? 3'b101 : 3'b000);
    end
    for (int k = 1; k <= 7; k++) begin
      step(3'b111);
      check_outs("post_rst_rise", (k >= 6) ? 3'b111 : 3'b010,
                 (k == 6) ? 3'b101 : 3'b000, 3'b000);
    end

`ifdef ENC_COND_GLITCH_CNT_EN
    // Test 6: bounce counting, saturation and clear priority
    check("glitch_clean", o_glitch_cnt, 24'h000000);
    for (int b = 0; b < 10; b++) bounce_ch0();
    check("glitch_10", o_glitch_cnt, 24'h00000A);
    for (int b = 10; b < 300; b++) bounce_ch0();
    check("glitch_sat", o_glitch_cnt, 24'h0000FF);
    check_outs("glitch_level", 3'b111, 3'b000, 3'b000);
    gstep(3'b110, 1'b0);
    gstep(3'b111, 1'b0);
    gstep(3'b111, 1'b0);
    gstep(3'b111, 1'b1);
    check("glitch_clr_wins", o_glitch_cnt, 24'h000000);
    gstep(3'b111, 1'b0);
    bounce_ch0();
    check("glitch_after_clr", o_glitch_cnt, 24'h000001);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
